// File: rtl/id_exe_reg_if.sv
// ID->EXE stage bundle: decoded control word, operands and stall/flush
// controls from upstream, plus the registered copies and debug counters.
interface id_exe_reg_if #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) ();

  logic                  mem_stall;
  logic                  flush;
  logic                  hazard_stall;

  logic [3:0]            exec_cmd_in;
  logic                  mem_r_en_in;
  logic                  mem_w_en_in;
  logic                  wb_en_in;
  logic                  is_imm_in;
  logic                  single_src_in;
  logic [1:0]            branch_type_in;
  logic [1:0]            swp_sel_in;
  logic [DATA_W-1:0]     pc_in;
  logic [DATA_W-1:0]     val1_in;
  logic [DATA_W-1:0]     val2_in;
  logic [DATA_W-1:0]     st_val_in;
  logic [REG_ADDR_W-1:0] dest_in;
  logic [REG_ADDR_W-1:0] src1_in;
  logic [REG_ADDR_W-1:0] src2_in;

  logic [3:0]            exec_cmd_out;
  logic                  mem_r_en_out;
  logic                  mem_w_en_out;
  logic                  wb_en_out;
  logic                  is_imm_out;
  logic                  single_src_out;
  logic [1:0]            branch_type_out;
  logic [1:0]            swp_sel_out;
  logic [DATA_W-1:0]     pc_out;
  logic [DATA_W-1:0]     val1_out;
  logic [DATA_W-1:0]     val2_out;
  logic [DATA_W-1:0]     st_val_out;
  logic [REG_ADDR_W-1:0] dest_out;
  logic [REG_ADDR_W-1:0] src1_out;
  logic [REG_ADDR_W-1:0] src2_out;
  logic                  valid_out;
  logic [CNT_W-1:0]      issue_cnt;
  logic [CNT_W-1:0]      bubble_cnt;
  logic                  swp_err;

  modport master (
    output mem_stall, flush, hazard_stall,
    output exec_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, is_imm_in, single_src_in,
    output branch_type_in, swp_sel_in, pc_in, val1_in, val2_in, st_val_in,
    output dest_in, src1_in, src2_in,
    input  exec_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, is_imm_out, single_src_out,
    input  branch_type_out, swp_sel_out, pc_out, val1_out, val2_out, st_val_out,
    input  dest_out, src1_out, src2_out,
    input  valid_out, issue_cnt, bubble_cnt, swp_err
  );

  modport slave (
    input  mem_stall, flush, hazard_stall,
    input  exec_cmd_in, mem_r_en_in, mem_w_en_in, wb_en_in, is_imm_in, single_src_in,
    input  branch_type_in, swp_sel_in, pc_in, val1_in, val2_in, st_val_in,
    input  dest_in, src1_in, src2_in,
    output exec_cmd_out, mem_r_en_out, mem_w_en_out, wb_en_out, is_imm_out, single_src_out,
    output branch_type_out, swp_sel_out, pc_out, val1_out, val2_out, st_val_out,
    output dest_out, src1_out, src2_out,
    output valid_out, issue_cnt, bubble_cnt, swp_err
  );

endinterface

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with memory-stall hold, flush/hazard bubbles,
// swap-pair sequencing check and saturating issue/bubble counters.
module id_exe_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic         clk,
  input  logic         rst,
  id_exe_reg_if.slave  bus
);

  typedef struct packed {
    logic [3:0]            exec_cmd;
    logic                  mem_r_en;
    logic                  mem_w_en;
    logic                  wb_en;
    logic                  is_imm;
    logic                  single_src;
    logic [1:0]            branch_type;
    logic [1:0]            swp_sel;
    logic [DATA_W-1:0]     pc;
    logic [DATA_W-1:0]     val1;
    logic [DATA_W-1:0]     val2;
    logic [DATA_W-1:0]     st_val;
    logic [REG_ADDR_W-1:0] dest;
    logic [REG_ADDR_W-1:0] src1;
    logic [REG_ADDR_W-1:0] src2;
  } stage_t;

  stage_t           stage_q, stage_d, in_c;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             swp_pending_q, swp_pending_d;
  logic             swp_err_q, swp_err_d;

  assign in_c = '{
    exec_cmd:    bus.exec_cmd_in,
    mem_r_en:    bus.mem_r_en_in,
    mem_w_en:    bus.mem_w_en_in,
    wb_en:       bus.wb_en_in,
    is_imm:      bus.is_imm_in,
    single_src:  bus.single_src_in,
    branch_type: bus.branch_type_in,
    swp_sel:     bus.swp_sel_in,
    pc:          bus.pc_in,
    val1:        bus.val1_in,
    val2:        bus.val2_in,
    st_val:      bus.st_val_in,
    dest:        bus.dest_in,
    src1:        bus.src1_in,
    src2:        bus.src2_in
  };

  // Next-state: stall holds everything, flush/hazard insert a bubble, else load.
  always_comb begin
    stage_d       = stage_q;
    valid_d       = valid_q;
    issue_cnt_d   = issue_cnt_q;
    bubble_cnt_d  = bubble_cnt_q;
    swp_pending_d = swp_pending_q;
    swp_err_d     = swp_err_q;

    if (bus.mem_stall) begin
      stage_d = stage_q;
    end else if (bus.flush || bus.hazard_stall) begin
      stage_d = '0;
      valid_d = 1'b0;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
      // A taken branch kills the first swap half; a hazard only delays the second.
      if (bus.flush) swp_pending_d = 1'b0;
    end else begin
      stage_d = in_c;
      valid_d = 1'b1;
      if (issue_cnt_q != '1) issue_cnt_d = issue_cnt_q + CNT_W'(1);
      unique case (bus.swp_sel_in)
        2'b01: begin
          if (swp_pending_q) swp_err_d = 1'b1;
          swp_pending_d = 1'b1;
        end
        2'b10: begin
          if (!swp_pending_q) swp_err_d = 1'b1;
          swp_pending_d = 1'b0;
        end
        2'b00: begin
          if (swp_pending_q) swp_err_d = 1'b1;
          swp_pending_d = 1'b0;
        end
        default: swp_err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q       <= '0;
      valid_q       <= 1'b0;
      issue_cnt_q   <= '0;
      bubble_cnt_q  <= '0;
      swp_pending_q <= 1'b0;
      swp_err_q     <= 1'b0;
    end else begin
      stage_q       <= stage_d;
      valid_q       <= valid_d;
      issue_cnt_q   <= issue_cnt_d;
      bubble_cnt_q  <= bubble_cnt_d;
      swp_pending_q <= swp_pending_d;
      swp_err_q     <= swp_err_d;
    end
  end

  assign bus.exec_cmd_out    = stage_q.exec_cmd;
  assign bus.mem_r_en_out    = stage_q.mem_r_en;
  assign bus.mem_w_en_out    = stage_q.mem_w_en;
  assign bus.wb_en_out       = stage_q.wb_en;
  assign bus.is_imm_out      = stage_q.is_imm;
  assign bus.single_src_out  = stage_q.single_src;
  assign bus.branch_type_out = stage_q.branch_type;
  assign bus.swp_sel_out     = stage_q.swp_sel;
  assign bus.pc_out          = stage_q.pc;
  assign bus.val1_out        = stage_q.val1;
  assign bus.val2_out        = stage_q.val2;
  assign bus.st_val_out      = stage_q.st_val;
  assign bus.dest_out        = stage_q.dest;
  assign bus.src1_out        = stage_q.src1;
  assign bus.src2_out        = stage_q.src2;
  assign bus.valid_out       = valid_q;
  assign bus.issue_cnt       = issue_cnt_q;
  assign bus.bubble_cnt      = bubble_cnt_q;
  assign bus.swp_err         = swp_err_q;

endmodule

// File: tb/tb_id_exe_reg.sv
// Randomized and directed bench for id_exe_reg against an event-level
// model: expected stage contents, unbounded issue/bubble tallies, swap state.
module tb_id_exe_reg;

  typedef struct packed {
    logic [3:0]  exec_cmd;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        wb_en;
    logic        is_imm;
    logic        single_src;
    logic [1:0]  branch_type;
    logic [1:0]  swp_sel;
    logic [31:0] pc;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [31:0] st_val;
    logic [4:0]  dest;
    logic [4:0]  src1;
    logic [4:0]  src2;
  } fld_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  id_exe_reg_if bus ();
  id_exe_reg dut (.clk(clk), .rst(rst), .bus(bus));

  // stimulus held by the bench
  fld_t stim;
  logic t_stall, t_flush, t_haz;
  bit   chk_en;

  // reference model state
  fld_t e_f;
  logic e_valid;
  int   n_issue, n_bubble;
  logic e_err, m_open;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] sat16(input int n);
    return (n > 65535) ? 64'd65535 : 64'(n);
  endfunction

  task automatic check_all();
    check_eq("exec_cmd",    64'(bus.exec_cmd_out),    64'(e_f.exec_cmd));
    check_eq("mem_r_en",    64'(bus.mem_r_en_out),    64'(e_f.mem_r_en));
    check_eq("mem_w_en",    64'(bus.mem_w_en_out),    64'(e_f.mem_w_en));
    check_eq("wb_en",       64'(bus.wb_en_out),       64'(e_f.wb_en));
    check_eq("is_imm",      64'(bus.is_imm_out),      64'(e_f.is_imm));
    check_eq("single_src",  64'(bus.single_src_out),  64'(e_f.single_src));
    check_eq("branch_type", 64'(bus.branch_type_out), 64'(e_f.branch_type));
    check_eq("swp_sel",     64'(bus.swp_sel_out),     64'(e_f.swp_sel));
    check_eq("pc",          64'(bus.pc_out),          64'(e_f.pc));
    check_eq("val1",        64'(bus.val1_out),        64'(e_f.val1));
    check_eq("val2",        64'(bus.val2_out),        64'(e_f.val2));
    check_eq("st_val",      64'(bus.st_val_out),      64'(e_f.st_val));
    check_eq("dest",        64'(bus.dest_out),        64'(e_f.dest));
    check_eq("src1",        64'(bus.src1_out),        64'(e_f.src1));
    check_eq("src2",        64'(bus.src2_out),        64'(e_f.src2));
    check_eq("valid",       64'(bus.valid_out),       64'(e_valid));
    check_eq("issue_cnt",   64'(bus.issue_cnt),       sat16(n_issue));
    check_eq("bubble_cnt",  64'(bus.bubble_cnt),      sat16(n_bubble));
    check_eq("swp_err",     64'(bus.swp_err),         64'(e_err));
  endtask

  // What one rising edge should do, described by event type.
  task automatic model_edge();
    if (rst) begin
      e_f = '0; e_valid = 1'b0; n_issue = 0; n_bubble = 0; e_err = 1'b0; m_open = 1'b0;
    end else if (t_stall) begin
      // nothing moves
    end else if (t_flush || t_haz) begin
      e_f = '0; e_valid = 1'b0; n_bubble++;
      if (t_flush) m_open = 1'b0;
    end else begin
      e_f = stim; e_valid = 1'b1; n_issue++;
      case (stim.swp_sel)
        2'b01: begin if (m_open) e_err = 1'b1; m_open = 1'b1; end
        2'b10: begin if (!m_open) e_err = 1'b1; m_open = 1'b0; end
        2'b00: begin if (m_open) e_err = 1'b1; m_open = 1'b0; end
        default: e_err = 1'b1;
      endcase
    end
  endtask

  task automatic drive();
    bus.mem_stall      = t_stall;
    bus.flush          = t_flush;
    bus.hazard_stall   = t_haz;
    bus.exec_cmd_in    = stim.exec_cmd;
    bus.mem_r_en_in    = stim.mem_r_en;
    bus.mem_w_en_in    = stim.mem_w_en;
    bus.wb_en_in       = stim.wb_en;
    bus.is_imm_in      = stim.is_imm;
    bus.single_src_in  = stim.single_src;
    bus.branch_type_in = stim.branch_type;
    bus.swp_sel_in     = stim.swp_sel;
    bus.pc_in          = stim.pc;
    bus.val1_in        = stim.val1;
    bus.val2_in        = stim.val2;
    bus.st_val_in      = stim.st_val;
    bus.dest_in        = stim.dest;
    bus.src1_in        = stim.src1;
    bus.src2_in        = stim.src2;
  endtask

  task automatic tick();
    drive();
    @(posedge clk);
    model_edge();
    #1;
    if (chk_en) check_all();
  endtask

  task automatic rand_stim(output fld_t s);
    s.exec_cmd    = 4'($urandom);
    s.mem_r_en    = 1'($urandom);
    s.mem_w_en    = 1'($urandom);
    s.wb_en       = 1'($urandom);
    s.is_imm      = 1'($urandom);
    s.single_src  = 1'($urandom);
    s.branch_type = 2'($urandom);
    s.swp_sel     = 2'($urandom);
    s.pc          = $urandom;
    s.val1        = $urandom;
    s.val2        = $urandom;
    s.st_val      = $urandom;
    s.dest        = 5'($urandom);
    s.src1        = 5'($urandom);
    s.src2        = 5'($urandom);
  endtask

  task automatic ctl(input logic s, input logic f, input logic h);
    t_stall = s; t_flush = f; t_haz = h;
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  initial begin
    fld_t s;
    chk_en = 1'b1;
    stim = '0; ctl(0, 0, 0);
    e_f = '0; e_valid = 0; n_issue = 0; n_bubble = 0; e_err = 0; m_open = 0;
    rst = 1'b1; tick(); tick(); rst = 1'b0;

    // ADD r3 = 5 + 7
    stim = '0; stim.wb_en = 1; stim.val1 = 5; stim.val2 = 7; stim.dest = 3; tick();
    check_eq("add_issue_cnt", 64'(bus.issue_cnt), 64'd1);

    // ST held through a 3-cycle memory stall with flush pending, then bubble
    stim = '0; stim.mem_w_en = 1; stim.st_val = 32'hAA; tick();
    for (int i = 0; i < 3; i++) begin
      rand_stim(s); stim = s; ctl(1, 1, 0); tick();
      check_eq("stall_hold_st", 64'(bus.st_val_out), 64'hAA);
    end
    ctl(0, 1, 0); tick();
    check_eq("flush_bubble_cnt", 64'(bus.bubble_cnt), 64'd1);

    // flush + hazard together: exactly one bubble
    stim = '0; stim.mem_r_en = 1; stim.wb_en = 1; stim.dest = 9; ctl(0, 1, 1); tick();
    check_eq("dual_bubble_cnt", 64'(bus.bubble_cnt), 64'd2);
    ctl(0, 0, 0);

    // legal swap pair, then a lone second half
    stim = '0; stim.swp_sel = 2'b01; stim.exec_cmd = 4'b1100; stim.wb_en = 1; tick();
    stim.swp_sel = 2'b10; stim.exec_cmd = 4'b1101; tick();
    check_eq("swap_pair_err", 64'(bus.swp_err), 64'd0);
    stim = '0; stim.swp_sel = 2'b10; tick();
    check_eq("lone_second_err", 64'(bus.swp_err), 64'd1);
    stim = '0; tick(); tick();

    // flush between halves orphans the second half
    do_reset();
    stim = '0; stim.swp_sel = 2'b01; tick();
    ctl(0, 1, 0); tick(); ctl(0, 0, 0);
    stim.swp_sel = 2'b10; tick();
    check_eq("flush_mid_swap_err", 64'(bus.swp_err), 64'd1);

    // hazard between halves keeps the pair intact
    do_reset();
    stim = '0; stim.swp_sel = 2'b01; tick();
    ctl(0, 0, 1); tick(); ctl(0, 0, 0);
    stim.swp_sel = 2'b10; tick();
    check_eq("hazard_mid_swap_err", 64'(bus.swp_err), 64'd0);

    // reset in the middle of a swap raises no error
    stim.swp_sel = 2'b01; tick();
    do_reset();
    stim = '0; tick();
    check_eq("reset_mid_swap_err", 64'(bus.swp_err), 64'd0);

    // randomized mix of loads, stalls, flushes, hazards and swap codes
    for (int i = 0; i < 400; i++) begin
      rand_stim(s);
      if ($urandom_range(0, 3) != 0) s.swp_sel = (i % 2 == 0) ? 2'b01 : 2'b10;
      stim = s;
      ctl($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 6) == 0);
      if ($urandom_range(0, 120) == 0) do_reset();
      else tick();
    end
    ctl(0, 0, 0);

    // issue counter saturation
    do_reset();
    chk_en = 1'b0;
    stim = '0;
    for (int i = 0; i < 65534; i++) begin
      stim.val1 = 32'(i); tick();
    end
    chk_en = 1'b1;
    check_eq("issue_cnt_fffe", 64'(bus.issue_cnt), 64'hFFFE);
    for (int i = 0; i < 3; i++) begin
      rand_stim(s); s.swp_sel = 2'b00; stim = s; tick();
      check_eq("issue_cnt_sat", 64'(bus.issue_cnt), 64'hFFFF);
    end
    rand_stim(s); stim = s; rst = 1'b1; tick(); rst = 1'b0;
    check_eq("reset_valid", 64'(bus.valid_out), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
